exe_stage: RTL and testbench

Execute pipeline stage of the five-stage MIPS core. It latches the decoded instruction bundle from the ID stage and drives the ALU. It issues the load/store address request to the data SRAM-like interface and hands the result bundle to the MEM stage. It also exports a bypass bundle back to ID for forwarding and load-use stall detection. All stage-to-stage movement uses valid/allowin handshakes.

---
 rtl/exe_stage_pkg.sv | 44 ++++
 rtl/exe_stage_alu.sv | 48 ++++
 rtl/exe_stage.sv | 99 +++++++++
 tb/tb_exe_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared core definitions: stage bus widths, ALU opcode bit positions and the ID->EXE bundle layout.
// Any stage that packs or unpacks these buses imports this package.
package exe_stage_pkg;

   localparam int DS2ES_BUS_W = 137;
   localparam int ES2MS_BUS_W = 71;
   localparam int ES2DS_BUS_W = 39;

   // One-hot ALU operation select, bit index into alu_op
   localparam int OP_ADD  = 0;
   localparam int OP_SUB  = 1;
   localparam int OP_SLT  = 2;
   localparam int OP_SLTU = 3;
   localparam int OP_AND  = 4;
   localparam int OP_NOR  = 5;
   localparam int OP_OR   = 6;
   localparam int OP_XOR  = 7;
   localparam int OP_SLL  = 8;
   localparam int OP_SRL  = 9;
   localparam int OP_SRA  = 10;
   localparam int OP_LUI  = 11;

   typedef struct packed {
      logic [11:0] alu_op;
      logic        src1_is_sa;
      logic        src1_is_pc;
      logic        src2_is_imm;
      logic        src2_is_uimm;
      logic        src2_is_8;
      logic        gr_we;
      logic        mem_we;
      logic        mem_re;
      logic [4:0]  dest;
      logic [15:0] imm;
      logic [31:0] rs_value;
      logic [31:0] rt_value;
      logic [31:0] pc;
   } ds2es_t;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU with a dedicated base+offset adder for load/store addresses.
// Zero latency; no flow control.
module exe_stage_alu
   import exe_stage_pkg::*;
(
   input  logic [11:0] i_alu_op,
   input  logic [31:0] i_src1,
   input  logic [31:0] i_src2,
   input  logic [31:0] i_mem_base,
   input  logic [15:0] i_mem_offset,
   output logic [31:0] o_alu_result,
   output logic [31:0] o_mem_addr
);

   logic [31:0] w_add;
   logic [31:0] w_sub;
   logic        w_slt;
   logic        w_sltu;
   logic [31:0] w_sra;
   logic [31:0] w_result;

   assign w_add  = i_src1 + i_src2;
   assign w_sub  = i_src1 - i_src2;
   assign w_slt  = $signed(i_src1) < $signed(i_src2);
   assign w_sltu = i_src1 < i_src2;
   assign w_sra  = 32'($signed(i_src2) >>> i_src1[4:0]);

   // Unselected ops contribute zero, so an all-zero alu_op yields a zero result
   always_comb begin
      w_result = '0;
      if (i_alu_op[OP_ADD])  w_result = w_result | w_add;
      if (i_alu_op[OP_SUB])  w_result = w_result | w_sub;
      if (i_alu_op[OP_SLT])  w_result = w_result | {31'b0, w_slt};
      if (i_alu_op[OP_SLTU]) w_result = w_result | {31'b0, w_sltu};
      if (i_alu_op[OP_AND])  w_result = w_result | (i_src1 & i_src2);
      if (i_alu_op[OP_NOR])  w_result = w_result | ~(i_src1 | i_src2);
      if (i_alu_op[OP_OR])   w_result = w_result | (i_src1 | i_src2);
      if (i_alu_op[OP_XOR])  w_result = w_result | (i_src1 ^ i_src2);
      if (i_alu_op[OP_SLL])  w_result = w_result | (i_src2 << i_src1[4:0]);
      if (i_alu_op[OP_SRL])  w_result = w_result | (i_src2 >> i_src1[4:0]);
      if (i_alu_op[OP_SRA])  w_result = w_result | w_sra;
      if (i_alu_op[OP_LUI])  w_result = w_result | {i_src2[15:0], 16'h0000};
   end

   assign o_alu_result = w_result;
   assign o_mem_addr   = i_mem_base + sext16(i_mem_offset);

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: one-cycle ALU pass-through; load/store issue stalls until addr_ok.
// Memory requests are only issued while MEM can accept, so an accepted request retires the same cycle.
module exe_stage
   import exe_stage_pkg::*;
#(
   parameter int DS2ES_W = DS2ES_BUS_W,
   parameter int ES2MS_W = ES2MS_BUS_W,
   parameter int ES2DS_W = ES2DS_BUS_W
)(
   input  logic               clk,
   input  logic               resetn,
   input  logic               ds_to_es_valid,
   input  logic [DS2ES_W-1:0] ds_to_es_bus,
   output logic               es_allowin,
   input  logic               ms_allowin,
   output logic               es_to_ms_valid,
   output logic [ES2MS_W-1:0] es_to_ms_bus,
   output logic [ES2DS_W-1:0] es_to_ds_bus,
   output logic               data_sram_req,
   output logic               data_sram_wr,
   output logic [1:0]         data_sram_size,
   output logic [3:0]         data_sram_wstrb,
   output logic [31:0]        data_sram_addr,
   output logic [31:0]        data_sram_wdata,
   input  logic               data_sram_addr_ok
);

   logic        r_es_valid;
   ds2es_t      r_es_bus;

   logic        w_mem_op;
   logic        w_ready_go;
   logic [31:0] w_src1;
   logic [31:0] w_src2;
   logic [31:0] w_alu_result;
   logic [31:0] w_mem_addr;

   assign w_mem_op       = r_es_bus.mem_re | r_es_bus.mem_we;
   assign data_sram_req  = r_es_valid & w_mem_op & ms_allowin;
   assign w_ready_go     = ~w_mem_op | (data_sram_req & data_sram_addr_ok);
   assign es_allowin     = ~r_es_valid | (w_ready_go & ms_allowin);
   assign es_to_ms_valid = r_es_valid & w_ready_go;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_es_valid <= 1'b0;
         r_es_bus   <= '0;
      end else if (es_allowin) begin
         r_es_valid <= ds_to_es_valid;
         if (ds_to_es_valid) begin
            r_es_bus <= ds2es_t'(ds_to_es_bus);
         end
      end
   end

   always_comb begin
      w_src1 = r_es_bus.rs_value;
      if (r_es_bus.src1_is_sa) begin
         w_src1 = {27'b0, r_es_bus.imm[10:6]};
      end else if (r_es_bus.src1_is_pc) begin
         w_src1 = r_es_bus.pc;
      end
   end

   always_comb begin
      w_src2 = r_es_bus.rt_value;
      if (r_es_bus.src2_is_imm) begin
         w_src2 = sext16(r_es_bus.imm);
      end else if (r_es_bus.src2_is_uimm) begin
         w_src2 = {16'b0, r_es_bus.imm};
      end else if (r_es_bus.src2_is_8) begin
         w_src2 = 32'd8;
      end
   end

   exe_stage_alu u_alu (
      .i_alu_op     (r_es_bus.alu_op),
      .i_src1       (w_src1),
      .i_src2       (w_src2),
      .i_mem_base   (r_es_bus.rs_value),
      .i_mem_offset (r_es_bus.imm),
      .o_alu_result (w_alu_result),
      .o_mem_addr   (w_mem_addr)
   );

   assign es_to_ms_bus = {r_es_bus.mem_re, r_es_bus.gr_we, r_es_bus.dest,
                          w_alu_result, r_es_bus.pc};

   // Qualified flags let ID ignore stale bundle contents when EXE is empty
   assign es_to_ds_bus = {r_es_valid & r_es_bus.gr_we, r_es_bus.dest,
                          w_alu_result, r_es_valid & r_es_bus.mem_re};

   assign data_sram_wr    = r_es_bus.mem_we;
   assign data_sram_size  = 2'd2;
   assign data_sram_wstrb = r_es_bus.mem_we ? 4'hf : 4'h0;
   assign data_sram_addr  = w_mem_addr;
   assign data_sram_wdata = r_es_bus.rt_value;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: reset, ALU pass-through, stalled/immediate loads and stores,
// MEM backpressure, back-to-back issue and asynchronous reset during a pending request.
module tb_exe_stage;

   localparam logic [7:0] F_SA   = 8'h80;
   localparam logic [7:0] F_PC   = 8'h40;
   localparam logic [7:0] F_IMM  = 8'h20;
   localparam logic [7:0] F_UIMM = 8'h10;
   localparam logic [7:0] F_8    = 8'h08;
   localparam logic [7:0] F_WE   = 8'h04;
   localparam logic [7:0] F_MWE  = 8'h02;
   localparam logic [7:0] F_MRE  = 8'h01;

   localparam logic [11:0] A_ADD = 12'h001;
   localparam logic [11:0] A_SUB = 12'h002;
   localparam logic [11:0] A_SLT = 12'h004;
   localparam logic [11:0] A_OR  = 12'h040;
   localparam logic [11:0] A_SLL = 12'h100;
   localparam logic [11:0] A_LUI = 12'h800;

   logic         clk;
   logic         resetn;
   logic         ds_to_es_valid;
   logic [136:0] ds_to_es_bus;
   logic         es_allowin;
   logic         ms_allowin;
   logic         es_to_ms_valid;
   logic [70:0]  es_to_ms_bus;
   logic [38:0]  es_to_ds_bus;
   logic         data_sram_req;
   logic         data_sram_wr;
   logic [1:0]   data_sram_size;
   logic [3:0]   data_sram_wstrb;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;
   logic         data_sram_addr_ok;

   int checks = 0;
   int errors = 0;

   exe_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .ds_to_es_valid    (ds_to_es_valid),
      .ds_to_es_bus      (ds_to_es_bus),
      .es_allowin        (es_allowin),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .es_to_ds_bus      (es_to_ds_bus),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_wstrb   (data_sram_wstrb),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [136:0] mk(input logic [11:0] op, input logic [7:0] flags,
                                       input logic [4:0] dest, input logic [15:0] imm,
                                       input logic [31:0] rs, input logic [31:0] rt,
                                       input logic [31:0] pc);
      return {op, flags, dest, imm, rs, rt, pc};
   endfunction

   // Back-to-back ALU stream with hand-computed results
   logic [136:0] b2b_op  [5];
   logic [31:0]  b2b_res [5];

   initial begin
      b2b_op[0] = mk(A_SUB, F_WE,        5'd1, 16'h0000, 32'd10, 32'd3, 32'h600);
      b2b_res[0] = 32'd7;
      b2b_op[1] = mk(A_SLL, F_SA | F_WE, 5'd2, 16'h0100, 32'd0, 32'd1, 32'h604);
      b2b_res[1] = 32'd16;
      b2b_op[2] = mk(A_LUI, F_UIMM | F_WE, 5'd3, 16'h1234, 32'd0, 32'd0, 32'h608);
      b2b_res[2] = 32'h1234_0000;
      b2b_op[3] = mk(A_SLT, F_WE,        5'd4, 16'h0000, 32'hFFFF_FFFF, 32'd1, 32'h60C);
      b2b_res[3] = 32'd1;
      b2b_op[4] = mk(A_ADD, F_PC | F_8 | F_WE, 5'd31, 16'h0000, 32'd0, 32'd0, 32'h500);
      b2b_res[4] = 32'h508;
   end

   initial begin
      resetn            = 1'b0;
      ds_to_es_valid    = 1'b0;
      ds_to_es_bus      = '0;
      ms_allowin        = 1'b1;
      data_sram_addr_ok = 1'b0;

      @(negedge clk);
      check("rst_allowin", 64'(es_allowin), 64'd1);
      check("rst_to_ms_valid", 64'(es_to_ms_valid), 64'd0);
      check("rst_req", 64'(data_sram_req), 64'd0);
      check("rst_to_ds_bus", 64'(es_to_ds_bus), 64'd0);
      check("rst_wstrb", 64'(data_sram_wstrb), 64'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("idle_to_ms_valid", 64'(es_to_ms_valid), 64'd0);
      check("idle_req", 64'(data_sram_req), 64'd0);

      // ADDU rs=5 rt=7 -> 12, dest 3
      @(negedge clk);
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(A_ADD, F_WE, 5'd3, 16'h0000, 32'd5, 32'd7, 32'h100);
      #1;
      check("addu_accept", 64'(es_allowin), 64'd1);
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      #1;
      check("addu_valid", 64'(es_to_ms_valid), 64'd1);
      check("addu_result", 64'(es_to_ms_bus[63:32]), 64'd12);
      check("addu_ms_dest", 64'(es_to_ms_bus[68:64]), 64'd3);
      check("addu_ms_pc", 64'(es_to_ms_bus[31:0]), 64'h100);
      check("addu_to_ds", 64'(es_to_ds_bus), 64'h46_0000_0018);
      @(negedge clk);
      #1;
      check("addu_drained", 64'(es_to_ms_valid), 64'd0);

      // LW with addr_ok after three stall cycles; an OR waits behind it in ID
      @(negedge clk);
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(A_ADD, F_IMM | F_WE | F_MRE, 5'd8, 16'hFFFC, 32'h1000, 32'h0, 32'h200);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         ds_to_es_bus      = mk(A_OR, F_WE, 5'd9, 16'h0000, 32'hF0, 32'h0F, 32'h204);
         data_sram_addr_ok = (i == 4);
         #1;
         check($sformatf("lw_req_%0d", i), 64'(data_sram_req), 64'd1);
         check($sformatf("lw_addr_%0d", i), 64'(data_sram_addr), 64'h0FFC);
         check($sformatf("lw_wr_%0d", i), 64'(data_sram_wr), 64'd0);
         check($sformatf("lw_ldflag_%0d", i), 64'(es_to_ds_bus[0]), 64'd1);
         check($sformatf("lw_allowin_%0d", i), 64'(es_allowin), (i == 4) ? 64'd1 : 64'd0);
         check($sformatf("lw_valid_%0d", i), 64'(es_to_ms_valid), (i == 4) ? 64'd1 : 64'd0);
      end
      check("lw_ms_memre", 64'(es_to_ms_bus[70]), 64'd1);
      check("lw_ms_dest", 64'(es_to_ms_bus[68:64]), 64'd8);
      @(negedge clk);
      ds_to_es_valid    = 1'b0;
      data_sram_addr_ok = 1'b0;
      #1;
      check("or_valid", 64'(es_to_ms_valid), 64'd1);
      check("or_result", 64'(es_to_ms_bus[63:32]), 64'hFF);
      check("or_req", 64'(data_sram_req), 64'd0);
      check("or_ldflag", 64'(es_to_ds_bus[0]), 64'd0);
      @(negedge clk);
      #1;
      check("or_drained", 64'(es_to_ms_valid), 64'd0);

      // SW with immediate addr_ok
      @(negedge clk);
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(A_ADD, F_IMM | F_MWE, 5'd0, 16'h0004, 32'h2000, 32'hDEAD_BEEF, 32'h300);
      @(negedge clk);
      ds_to_es_valid    = 1'b0;
      data_sram_addr_ok = 1'b1;
      #1;
      check("sw_req", 64'(data_sram_req), 64'd1);
      check("sw_wr", 64'(data_sram_wr), 64'd1);
      check("sw_wstrb", 64'(data_sram_wstrb), 64'hF);
      check("sw_size", 64'(data_sram_size), 64'd2);
      check("sw_wdata", 64'(data_sram_wdata), 64'hDEAD_BEEF);
      check("sw_addr", 64'(data_sram_addr), 64'h2004);
      check("sw_valid", 64'(es_to_ms_valid), 64'd1);
      check("sw_gr_we", 64'(es_to_ds_bus[38]), 64'd0);
      @(negedge clk);
      data_sram_addr_ok = 1'b0;
      #1;
      check("sw_req_done", 64'(data_sram_req), 64'd0);
      check("sw_drained", 64'(es_to_ms_valid), 64'd0);

      // LW blocked by ms_allowin=0; stray addr_ok while req=0 must be ignored
      @(negedge clk);
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(A_ADD, F_IMM | F_WE | F_MRE, 5'd4, 16'h0008, 32'h3000, 32'h0, 32'h400);
      @(negedge clk);
      ds_to_es_valid    = 1'b0;
      ms_allowin        = 1'b0;
      data_sram_addr_ok = 1'b1;
      #1;
      check("bp_req", 64'(data_sram_req), 64'd0);
      check("bp_valid", 64'(es_to_ms_valid), 64'd0);
      check("bp_allowin", 64'(es_allowin), 64'd0);
      @(negedge clk);
      #1;
      check("bp_held_pc", 64'(es_to_ms_bus[31:0]), 64'h400);
      check("bp_held_ld", 64'(es_to_ds_bus[0]), 64'd1);
      check("bp_held_req", 64'(data_sram_req), 64'd0);
      @(negedge clk);
      ms_allowin = 1'b1;
      #1;
      check("bp_issue_req", 64'(data_sram_req), 64'd1);
      check("bp_issue_addr", 64'(data_sram_addr), 64'h3008);
      check("bp_issue_valid", 64'(es_to_ms_valid), 64'd1);
      @(negedge clk);
      data_sram_addr_ok = 1'b0;
      #1;
      check("bp_drained", 64'(es_to_ms_valid), 64'd0);

      // Back-to-back ALU ops, one result per cycle
      for (int i = 0; i <= 5; i++) begin
         @(negedge clk);
         if (i < 5) begin
            ds_to_es_valid = 1'b1;
            ds_to_es_bus   = b2b_op[i];
         end else begin
            ds_to_es_valid = 1'b0;
         end
         #1;
         check($sformatf("b2b_allowin_%0d", i), 64'(es_allowin), 64'd1);
         if (i > 0) begin
            check($sformatf("b2b_valid_%0d", i - 1), 64'(es_to_ms_valid), 64'd1);
            check($sformatf("b2b_res_%0d", i - 1), 64'(es_to_ms_bus[63:32]), 64'(b2b_res[i - 1]));
         end
      end

      // Reset while a load request is outstanding
      @(negedge clk);
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(A_ADD, F_IMM | F_WE | F_MRE, 5'd6, 16'h0000, 32'h5000, 32'h0, 32'h700);
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      #1;
      check("mid_req_before", 64'(data_sram_req), 64'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("mid_req_after", 64'(data_sram_req), 64'd0);
      check("mid_valid_after", 64'(es_to_ms_valid), 64'd0);
      check("mid_allowin_after", 64'(es_allowin), 64'd1);
      check("mid_to_ds_after", 64'(es_to_ds_bus), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst_valid", 64'(es_to_ms_valid), 64'd0);
      check("post_rst_req", 64'(data_sram_req), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
